hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller.sv | 159 +++++++++++++++
 tb/tb_hazard_controller.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: operand bypass selects, load-use interlock,
// branch flush, data-memory wait FSM with timeout, and a stall counter.
module hazard_controller #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic             rs1_used_d,
    input  logic             rs2_used_d,
    input  logic [4:0]       rs1_e,
    input  logic [4:0]       rs2_e,
    input  logic [4:0]       rd_e,
    input  logic [1:0]       result_src_e,
    input  logic             reg_write_e,
    input  logic             reg_write_m,
    input  logic             reg_write_w,
    input  logic [4:0]       rd_m,
    input  logic [4:0]       rd_w,
    input  logic             pc_src_e,
    input  logic             mem_req_m,
    input  logic             mem_ack,
    output logic [1:0]       forward_a_e,
    output logic [1:0]       forward_b_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_w,
    output logic             mem_busy,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    // Wait counter only needs to reach MEM_TIMEOUT-1; the edge that would
    // take it to MEM_TIMEOUT moves the FSM into ERROR instead.
    localparam int            WCW  = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] LAST = WCW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_ERROR    = 2'd2
    } state_t;

    state_t           r_state;
    logic [WCW-1:0]   r_wait_cnt;
    logic             r_mem_err;
    logic [CNT_W-1:0] r_stall_cycles;

    logic w_lu;
    logic w_ms;

    // Bypass select for one Execute source: Memory result beats Writeback.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs))
            return 2'b10;
        else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Hazard detection: load-use in Execute and memory stall from FSM state.
    always_comb begin
        w_lu = (result_src_e == 2'd1) && reg_write_e && (rd_e != 5'd0) &&
               ((rs1_used_d && (rs1_d == rd_e)) || (rs2_used_d && (rs2_d == rd_e)));
        case (r_state)
            S_IDLE:     w_ms = mem_req_m && !mem_ack;
            S_MEM_WAIT: w_ms = !mem_ack;
            S_ERROR:    w_ms = 1'b1;
            default:    w_ms = 1'b0;
        endcase
    end

    // Stall/flush priority: memory stall, then redirect, then load-use.
    // Everything is held low while reset is asserted.
    always_comb begin
        forward_a_e = 2'b00;
        forward_b_e = 2'b00;
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        stall_m     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        flush_w     = 1'b0;
        mem_busy    = 1'b0;
        if (!rst) begin
            forward_a_e = fwd_sel(rs1_e);
            forward_b_e = fwd_sel(rs2_e);
            mem_busy    = w_ms;
            if (w_ms) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else if (pc_src_e) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (w_lu) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    // Memory FSM: a same-cycle ack in IDLE is a zero-wait access; ERROR is terminal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mem_req_m && !mem_ack) begin
                        r_state    <= S_MEM_WAIT;
                        r_wait_cnt <= '0;
                    end
                end
                S_MEM_WAIT: begin
                    if (mem_ack) begin
                        r_state <= S_IDLE;
                    end else if (r_wait_cnt == LAST) begin
                        r_state   <= S_ERROR;
                        r_mem_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_ERROR: begin
                    r_mem_err <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Saturating count of cycles in which fetch was held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stall_cycles <= '0;
        else if (stall_f && (r_stall_cycles != {CNT_W{1'b1}}))
            r_stall_cycles <= r_stall_cycles + 1'b1;
    end

    assign mem_err      = r_mem_err;
    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: forwarding, load-use, branch flush,
// memory wait, timeout, reset behaviour and counter saturation.
module tb_hazard_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic        rs1_used_d, rs2_used_d;
    logic [1:0]  result_src_e;
    logic        reg_write_e, reg_write_m, reg_write_w;
    logic        pc_src_e, mem_req_m, mem_ack;

    logic [1:0]  forward_a_e, forward_b_e;
    logic        stall_f, stall_d, stall_e, stall_m;
    logic        flush_d, flush_e, flush_w, mem_busy, mem_err;
    logic [31:0] stall_cycles;

    logic [1:0]  s_fa, s_fb;
    logic        s_sf, s_sd, s_se, s_sm, s_fd, s_fe, s_fw, s_busy, s_err;
    logic [1:0]  s_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_controller #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_used_d(rs1_used_d), .rs2_used_d(rs2_used_d),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .result_src_e(result_src_e),
        .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .rd_m(rd_m), .rd_w(rd_w), .pc_src_e(pc_src_e), .mem_req_m(mem_req_m), .mem_ack(mem_ack),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
        .mem_busy(mem_busy), .mem_err(mem_err), .stall_cycles(stall_cycles)
    );

    // Narrow-counter copy on the same stimulus, used only for saturation.
    hazard_controller #(.MEM_TIMEOUT(4), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_used_d(rs1_used_d), .rs2_used_d(rs2_used_d),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .result_src_e(result_src_e),
        .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .rd_m(rd_m), .rd_w(rd_w), .pc_src_e(pc_src_e), .mem_req_m(mem_req_m), .mem_ack(mem_ack),
        .forward_a_e(s_fa), .forward_b_e(s_fb),
        .stall_f(s_sf), .stall_d(s_sd), .stall_e(s_se), .stall_m(s_sm),
        .flush_d(s_fd), .flush_e(s_fe), .flush_w(s_fw),
        .mem_busy(s_busy), .mem_err(s_err), .stall_cycles(s_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        rs1_d = 0; rs2_d = 0; rs1_used_d = 0; rs2_used_d = 0;
        rs1_e = 0; rs2_e = 0; rd_e = 0; result_src_e = 0;
        reg_write_e = 0; reg_write_m = 0; reg_write_w = 0;
        rd_m = 0; rd_w = 0; pc_src_e = 0; mem_req_m = 0; mem_ack = 0;
    endtask

    // Advance one edge; inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lu();
        result_src_e = 2'd1; reg_write_e = 1; rd_e = 5'd7; rs2_d = 5'd7; rs2_used_d = 1;
    endtask

    initial begin
        clr();
        rst = 1;
        #2;
        // reset state
        chk("rst_cnt", stall_cycles, 0);
        chk("rst_err", mem_err, 0);
        chk("rst_busy", mem_busy, 0);
        // outputs held low during reset even with hazards/requests present
        pc_src_e = 1; reg_write_m = 1; rd_m = 5; rs1_e = 5; mem_req_m = 1; set_lu();
        #1;
        chk("rst_flush_d", flush_d, 0);
        chk("rst_fwd_a", forward_a_e, 0);
        chk("rst_busy_req", mem_busy, 0);
        chk("rst_stall_f", stall_f, 0);
        clr();
        tick();
        rst = 0;

        // forwarding
        rd_m = 5; reg_write_m = 1; rd_w = 5; reg_write_w = 1; rs1_e = 5;
        #1 chk("fwd_a_mem", forward_a_e, 2'b10);
        rd_m = 0;
        #1 chk("fwd_a_wb", forward_a_e, 2'b01);
        rs2_e = 5;
        #1 chk("fwd_b_wb", forward_b_e, 2'b01);
        reg_write_w = 0;
        #1 chk("fwd_b_none", forward_b_e, 2'b00);
        reg_write_w = 1; rd_w = 0; rs1_e = 0;
        #1 chk("fwd_a_x0", forward_a_e, 2'b00);
        clr();

        // load-use: one stall cycle
        set_lu();
        #1;
        chk("lu_stall_f", stall_f, 1);
        chk("lu_stall_d", stall_d, 1);
        chk("lu_flush_e", flush_e, 1);
        chk("lu_stall_e", stall_e, 0);
        chk("lu_flush_d", flush_d, 0);
        tick();
        clr();                          // load has moved on, bubble in Execute
        #1 chk("lu_released", stall_f, 0);
        chk("lu_cnt", stall_cycles, 1);
        set_lu(); rs2_used_d = 0;
        #1 chk("lu_unused", stall_f, 0);
        rs1_used_d = 1; rs1_d = 7;
        #1 chk("lu_rs1", stall_d, 1);
        result_src_e = 2'd2;
        #1 chk("lu_not_load", stall_f, 0);
        result_src_e = 2'd1; rd_e = 0; rs1_d = 0;
        #1 chk("lu_x0", stall_f, 0);

        // branch with load-use
        set_lu(); pc_src_e = 1;
        #1;
        chk("br_flush_d", flush_d, 1);
        chk("br_flush_e", flush_e, 1);
        chk("br_stall_f", stall_f, 0);
        chk("br_stall_d", stall_d, 0);
        clr();

        // memory wait: 3 stall cycles then ack
        mem_req_m = 1;
        #1;
        chk("mw_busy1", mem_busy, 1);
        chk("mw_stall_m1", stall_m, 1);
        chk("mw_flush_w1", flush_w, 1);
        tick();
        set_lu(); pc_src_e = 1;         // suppressed by the memory stall
        #1;
        chk("mw_busy2", mem_busy, 1);
        chk("mw_stall_e2", stall_e, 1);
        chk("mw_no_flush_d", flush_d, 0);
        chk("mw_no_flush_e", flush_e, 0);
        clr(); mem_req_m = 1;
        tick();
        #1 chk("mw_busy3", stall_f, 1);
        tick();
        mem_ack = 1;
        #1;
        chk("mw_ack_busy", mem_busy, 0);
        chk("mw_ack_stall", stall_f, 0);
        tick();
        clr();
        #1 chk("mw_idle", mem_busy, 0);  // MEM_WAIT would stall with ack low
        chk("mw_cnt", stall_cycles, 4);
        chk("sat_cnt", s_cnt, 2'd3);

        // zero-wait access
        mem_req_m = 1; mem_ack = 1;
        #1 chk("zw_busy", mem_busy, 0);
        tick();
        clr();
        #1 chk("zw_idle", mem_busy, 0);
        chk("zw_cnt", stall_cycles, 4);

        // timeout
        mem_req_m = 1;
        tick(); tick(); tick(); tick(); // IDLE edge + 3 MEM_WAIT edges
        #1;
        chk("to_err_early", mem_err, 0);
        chk("to_busy", mem_busy, 1);
        tick();                          // 4th MEM_WAIT edge
        #1 chk("to_err", mem_err, 1);
        mem_req_m = 0; mem_ack = 1;
        #1;
        chk("err_busy", mem_busy, 1);
        chk("err_stall_f", stall_f, 1);
        tick(); tick();
        #1 chk("err_sticky", mem_err, 1);
        chk("err_cnt", stall_cycles, 11);
        rst = 1;
        #1;
        chk("err_rst_stall", stall_f, 0);
        chk("err_rst_busy", mem_busy, 0);
        chk("err_rst_err", mem_err, 0);
        chk("err_rst_cnt", stall_cycles, 0);
        tick();
        rst = 0; clr();
        #1 chk("err_rel_idle", mem_busy, 0);

        // reset mid-wait
        mem_req_m = 1;
        tick(); tick();
        mem_req_m = 0;
        #1 chk("mid_wait", mem_busy, 1);
        rst = 1;
        #1;
        chk("mid_rst_busy", mem_busy, 0);
        chk("mid_rst_flush_w", flush_w, 0);
        chk("mid_rst_stall_m", stall_m, 0);
        #2 rst = 0;
        #1;
        chk("mid_rel_idle", mem_busy, 0);
        chk("mid_rel_err", mem_err, 0);
        tick();
        #1 chk("mid_rel_cnt", stall_cycles, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net in case the sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "bench timeout");
    end

endmodule
